// File: rtl/gray_step_arbiter_pkg.sv
// Shared definitions for the gray step arbiter: Gray code table, FSM states,
// requester indices and the single-step Gray successor function.
package gray_step_arbiter_pkg;

  // Gray codes in counting order
  localparam logic [2:0] G0 = 3'b000;
  localparam logic [2:0] G1 = 3'b001;
  localparam logic [2:0] G2 = 3'b011;
  localparam logic [2:0] G3 = 3'b010;
  localparam logic [2:0] G4 = 3'b110;
  localparam logic [2:0] G5 = 3'b111;
  localparam logic [2:0] G6 = 3'b101;
  localparam logic [2:0] G7 = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic ReqIdx0 = 1'b0;
  localparam logic ReqIdx1 = 1'b1;

  function automatic logic [2:0] gray_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      G0:      nxt = G1;
      G1:      nxt = G2;
      G2:      nxt = G3;
      G3:      nxt = G4;
      G4:      nxt = G5;
      G5:      nxt = G6;
      G6:      nxt = G7;
      G7:      nxt = G0;
      default: nxt = G0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gray_step_arbiter_if.sv
// Requester-facing bus of the gray step arbiter: requests, step counts, abort,
// and the grant/status/counter outputs.
interface gray_step_arbiter_if #(
  parameter int unsigned STEP_W = 4
);
  logic [1:0]        Req;
  logic [STEP_W-1:0] Steps0;
  logic [STEP_W-1:0] Steps1;
  logic              Abort;
  logic [1:0]        Gnt;
  logic              Busy;
  logic              Done;
  logic              Aborted;
  logic [2:0]        Output;
  logic              Overflow;

  modport master (
    output Req, Steps0, Steps1, Abort,
    input  Gnt, Busy, Done, Aborted, Output, Overflow
  );

  modport slave (
    input  Req, Steps0, Steps1, Abort,
    output Gnt, Busy, Done, Aborted, Output, Overflow
  );
endinterface

// File: rtl/gray_step_arbiter_gray3_core.sv
// 3-bit Gray counter core: advances one code per enabled cycle and flags the
// 100->000 wrap combinationally.
module gray3_core
  import gray_step_arbiter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  output logic [2:0] Output,
  output logic       Wrap
);

  logic [2:0] code_q, code_d;

  always_comb begin
    code_d = code_q;
    if (En) begin
      code_d = gray_next(code_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      code_q <= G0;
    end else begin
      code_q <= code_d;
    end
  end

  assign Output = code_q;
  assign Wrap   = En && (code_q == G7);

endmodule

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter sharing one Gray counter core between two requesters;
// each transaction advances the counter a latched number of steps.
module gray_step_arbiter
  import gray_step_arbiter_pkg::*;
#(
  parameter int unsigned STEP_W = 4
) (
  input logic                Clk,
  input logic                Reset,
  gray_step_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              aborted_q, aborted_d;
  logic              overflow_q;

  logic              core_en;
  logic              core_wrap;
  logic [2:0]        core_code;

  logic              winner;
  logic [STEP_W-1:0] win_steps;

  // On a tie the requester that did not win last time goes first
  always_comb begin
    if (bus.Req == 2'b11) begin
      winner = ~ptr_q;
    end else if (bus.Req[ReqIdx1]) begin
      winner = ReqIdx1;
    end else begin
      winner = ReqIdx0;
    end
    win_steps = (winner == ReqIdx1) ? bus.Steps1 : bus.Steps0;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    core_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.Req != 2'b00) begin
          ptr_d     = winner;
          gnt_d     = 2'b01 << winner;
          rem_d     = win_steps;
          aborted_d = 1'b0;
          state_d   = (win_steps != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        // Abort wins over the final step: no advance in the abort cycle
        if (bus.Abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          core_en = 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == STEP_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d   = StIdle;
        gnt_d     = 2'b00;
        aborted_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      gnt_q      <= 2'b00;
      ptr_q      <= 1'b1;
      rem_q      <= '0;
      aborted_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      aborted_q  <= aborted_d;
      overflow_q <= overflow_q | core_wrap;
    end
  end

  gray3_core u_core (
    .Clk    (Clk),
    .Reset  (Reset),
    .En     (core_en),
    .Output (core_code),
    .Wrap   (core_wrap)
  );

  assign bus.Gnt      = gnt_q;
  assign bus.Busy     = (state_q != StIdle);
  assign bus.Done     = (state_q == StDone);
  assign bus.Aborted  = aborted_q;
  assign bus.Output   = core_code;
  assign bus.Overflow = overflow_q;

endmodule
